// File: rtl/alu_pkg.sv
// Shared op_code encodings and types for the registered ALU.
// Optional signed-overflow flag is enabled with `define ALU_OVF_FLAG_EN.
package alu_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_ADD = 3'b000;
   localparam op_t OP_SUB = 3'b001;
   localparam op_t OP_AND = 3'b010;
   localparam op_t OP_OR  = 3'b011;
   localparam op_t OP_XOR = 3'b100;
   localparam op_t OP_EQ  = 3'b101;
   localparam op_t OP_GT  = 3'b110;
   localparam op_t OP_SHL = 3'b111;

endpackage : alu_pkg

// File: rtl/alu_if.sv
// Request/response bundle between a requester (master) and the ALU (slave).
// ovf_flag is present only when ALU_OVF_FLAG_EN is defined.
interface alu_if #(
   parameter int unsigned WIDTH = 8
);
   import alu_pkg::*;

   logic             in_valid;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   op_t              op_code;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic             zero_flag;
   logic             carry_flag;
`ifdef ALU_OVF_FLAG_EN
   logic             ovf_flag;
`endif

   modport master (
      output in_valid, A, B, op_code,
      input  out_valid, result, zero_flag, carry_flag
`ifdef ALU_OVF_FLAG_EN
      , input ovf_flag
`endif
   );

   modport slave (
      input  in_valid, A, B, op_code,
      output out_valid, result, zero_flag, carry_flag
`ifdef ALU_OVF_FLAG_EN
      , output ovf_flag
`endif
   );

endinterface : alu_if

// File: rtl/alu_comb.sv
// Combinational ALU datapath: next result, carry and (optionally) signed overflow.
// ovf_c exists only when ALU_OVF_FLAG_EN is defined.
module alu_comb
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  op_t              op_code,
   output logic [WIDTH-1:0] result_c,
   output logic             carry_c
`ifdef ALU_OVF_FLAG_EN
   ,
   output logic             ovf_c
`endif
);

   localparam int unsigned MSB = WIDTH - 1;

   logic [WIDTH:0] sum_ext;
   logic [WIDTH:0] diff_ext;

   // Extended by one bit so the top bit is carry-out for ADD and borrow for SUB.
   assign sum_ext  = {1'b0, A} + {1'b0, B};
   assign diff_ext = {1'b0, A} - {1'b0, B};

   always_comb begin
      result_c = '0;
      carry_c  = 1'b0;
      case (op_code)
         OP_ADD: begin
            result_c = sum_ext[WIDTH-1:0];
            carry_c  = sum_ext[WIDTH];
         end
         OP_SUB: begin
            result_c = diff_ext[WIDTH-1:0];
            carry_c  = diff_ext[WIDTH];
         end
         OP_AND: result_c = A & B;
         OP_OR:  result_c = A | B;
         OP_XOR: result_c = A ^ B;
         OP_EQ:  result_c = WIDTH'(A == B);
         OP_GT:  result_c = WIDTH'(A > B);
         OP_SHL: begin
            result_c = {A[WIDTH-2:0], 1'b0};
            carry_c  = A[MSB];
         end
         default: begin
            result_c = '0;
            carry_c  = 1'b0;
         end
      endcase
   end

`ifdef ALU_OVF_FLAG_EN
   // Two's-complement overflow: result sign disagrees with what the operand signs allow.
   always_comb begin
      ovf_c = 1'b0;
      case (op_code)
         OP_ADD:  ovf_c = (A[MSB] == B[MSB]) && (sum_ext[MSB]  != A[MSB]);
         OP_SUB:  ovf_c = (A[MSB] != B[MSB]) && (diff_ext[MSB] != A[MSB]);
         default: ovf_c = 1'b0;
      endcase
   end
`endif

endmodule : alu_comb

// File: rtl/alu_core.sv
// Registered WIDTH-bit ALU: one-cycle latency, result/flags hold while idle.
// Define ALU_OVF_FLAG_EN to add the registered signed-overflow flag.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input logic  clk,
   input logic  rst,
   alu_if.slave bus
);

   logic [WIDTH-1:0] result_c;
   logic             carry_c;
`ifdef ALU_OVF_FLAG_EN
   logic             ovf_c;
`endif

   alu_comb #(
      .WIDTH (WIDTH)
   ) u_alu_comb (
      .A        (bus.A),
      .B        (bus.B),
      .op_code  (bus.op_code),
      .result_c (result_c),
      .carry_c  (carry_c)
`ifdef ALU_OVF_FLAG_EN
      ,
      .ovf_c    (ovf_c)
`endif
   );

   // Capture on accepted request; reset wins over a same-cycle request.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid  <= 1'b0;
         bus.result     <= '0;
         bus.zero_flag  <= 1'b0;
         bus.carry_flag <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
         bus.ovf_flag   <= 1'b0;
`endif
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.result     <= result_c;
            bus.zero_flag  <= (result_c == '0);
            bus.carry_flag <= carry_c;
`ifdef ALU_OVF_FLAG_EN
            bus.ovf_flag   <= ovf_c;
`endif
         end
      end
   end

endmodule : alu_core

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core (8-bit), one task per feature.
// Overflow checks are compiled in when ALU_OVF_FLAG_EN is defined.
module tb_alu_core;
   import alu_pkg::*;

   localparam int unsigned WIDTH = 8;

   typedef struct {
      op_t        op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] r;
      logic       c;
      logic       z;
      logic       o;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   alu_if #(.WIDTH(WIDTH)) bus ();

   alu_core #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Drive one cycle of stimulus at negedge, return #1 after the capturing edge.
   task automatic drive(input logic v, input op_t op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      bus.in_valid = v;
      bus.op_code  = op;
      bus.A        = a;
      bus.B        = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, OP_ADD, 8'd0, 8'd0);
      rst = 1'b0;
      drive(1'b1, OP_ADD, 8'd200, 8'd100);
      @(negedge clk);
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.op_code  = OP_ADD;
      bus.A        = 8'd255;
      bus.B        = 8'd1;
      @(posedge clk);
      #1;
      n_assert++;
      if ({bus.out_valid, bus.result, bus.carry_flag, bus.zero_flag} !== 11'b0) begin
         n_fail++;
         $display("FAIL reset: valid=%b result=%0d carry=%b zero=%b, required all 0",
                  bus.out_valid, bus.result, bus.carry_flag, bus.zero_flag);
      end
`ifdef ALU_OVF_FLAG_EN
      n_assert++;
      if (bus.ovf_flag !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ovf: ovf=%b required 0", bus.ovf_flag);
      end
`endif
      rst = 1'b0;
   endtask

   task automatic test_add();
      vec_t v[4];
      v[0] = '{OP_ADD, 8'd10,  8'd5,   8'd15,  1'b0, 1'b0, 1'b0};
      v[1] = '{OP_ADD, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 1'b0};
      v[2] = '{OP_ADD, 8'd100, 8'd100, 8'd200, 1'b0, 1'b0, 1'b1};
      v[3] = '{OP_ADD, 8'd255, 8'd1,   8'd0,   1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, v[i].op, v[i].a, v[i].b);
         n_assert++;
         if ({bus.out_valid, bus.result, bus.carry_flag, bus.zero_flag} !== {1'b1, v[i].r, v[i].c, v[i].z}) begin
            n_fail++;
            $display("FAIL add[%0d]: valid=%b result=%0d carry=%b zero=%b, required 1/%0d/%b/%b",
                     i, bus.out_valid, bus.result, bus.carry_flag, bus.zero_flag, v[i].r, v[i].c, v[i].z);
         end
`ifdef ALU_OVF_FLAG_EN
         n_assert++;
         if (bus.ovf_flag !== v[i].o) begin
            n_fail++;
            $display("FAIL add_ovf[%0d]: ovf=%b required %b", i, bus.ovf_flag, v[i].o);
         end
`endif
      end
   endtask

   task automatic test_sub();
      vec_t v[4];
      v[0] = '{OP_SUB, 8'd20,   8'd7,  8'd13,  1'b0, 1'b0, 1'b0};
      v[1] = '{OP_SUB, 8'd7,    8'd20, 8'd243, 1'b1, 1'b0, 1'b0};
      v[2] = '{OP_SUB, 8'd9,    8'd9,  8'd0,   1'b0, 1'b1, 1'b0};
      v[3] = '{OP_SUB, 8'h80,   8'd1,  8'h7F,  1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, v[i].op, v[i].a, v[i].b);
         n_assert++;
         if ({bus.out_valid, bus.result, bus.carry_flag, bus.zero_flag} !== {1'b1, v[i].r, v[i].c, v[i].z}) begin
            n_fail++;
            $display("FAIL sub[%0d]: valid=%b result=%0d carry=%b zero=%b, required 1/%0d/%b/%b",
                     i, bus.out_valid, bus.result, bus.carry_flag, bus.zero_flag, v[i].r, v[i].c, v[i].z);
         end
`ifdef ALU_OVF_FLAG_EN
         n_assert++;
         if (bus.ovf_flag !== v[i].o) begin
            n_fail++;
            $display("FAIL sub_ovf[%0d]: ovf=%b required %b", i, bus.ovf_flag, v[i].o);
         end
`endif
      end
   endtask

   task automatic test_logic_cmp();
      vec_t v[8];
      v[0] = '{OP_AND, 8'd5,   8'd3,   8'd1, 1'b0, 1'b0, 1'b0};
      v[1] = '{OP_OR,  8'd5,   8'd3,   8'd7, 1'b0, 1'b0, 1'b0};
      v[2] = '{OP_XOR, 8'd5,   8'd3,   8'd6, 1'b0, 1'b0, 1'b0};
      v[3] = '{OP_AND, 8'hF0,  8'h0F,  8'd0, 1'b0, 1'b1, 1'b0};
      v[4] = '{OP_EQ,  8'd12,  8'd12,  8'd1, 1'b0, 1'b0, 1'b0};
      v[5] = '{OP_EQ,  8'd12,  8'd13,  8'd0, 1'b0, 1'b1, 1'b0};
      v[6] = '{OP_GT,  8'd15,  8'd8,   8'd1, 1'b0, 1'b0, 1'b0};
      v[7] = '{OP_GT,  8'd8,   8'd15,  8'd0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, v[i].op, v[i].a, v[i].b);
         n_assert++;
         if ({bus.out_valid, bus.result, bus.carry_flag, bus.zero_flag} !== {1'b1, v[i].r, v[i].c, v[i].z}) begin
            n_fail++;
            $display("FAIL logic_cmp[%0d] op=%0d: valid=%b result=%0d carry=%b zero=%b, required 1/%0d/%b/%b",
                     i, v[i].op, bus.out_valid, bus.result, bus.carry_flag, bus.zero_flag, v[i].r, v[i].c, v[i].z);
         end
      end
   endtask

   task automatic test_shl();
      vec_t v[3];
      v[0] = '{OP_SHL, 8'd4,  8'hFF, 8'd8,  1'b0, 1'b0, 1'b0};
      v[1] = '{OP_SHL, 8'h80, 8'hFF, 8'd0,  1'b1, 1'b1, 1'b0};
      v[2] = '{OP_SHL, 8'hC1, 8'h00, 8'h82, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, v[i].op, v[i].a, v[i].b);
         n_assert++;
         if ({bus.out_valid, bus.result, bus.carry_flag, bus.zero_flag} !== {1'b1, v[i].r, v[i].c, v[i].z}) begin
            n_fail++;
            $display("FAIL shl[%0d]: valid=%b result=%0d carry=%b zero=%b, required 1/%0d/%b/%b",
                     i, bus.out_valid, bus.result, bus.carry_flag, bus.zero_flag, v[i].r, v[i].c, v[i].z);
         end
      end
   endtask

   task automatic test_hold();
      drive(1'b1, OP_ADD, 8'd200, 8'd100);
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, OP_SHL, 8'd0, 8'd0);
         n_assert++;
         if ({bus.out_valid, bus.result, bus.carry_flag, bus.zero_flag} !== {1'b0, 8'd44, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL hold[%0d]: valid=%b result=%0d carry=%b zero=%b, required 0/44/1/0",
                     i, bus.out_valid, bus.result, bus.carry_flag, bus.zero_flag);
         end
      end
   endtask

   task automatic test_back_to_back();
      vec_t v[5];
      v[0] = '{OP_ADD, 8'd1,   8'd2,   8'd3,   1'b0, 1'b0, 1'b0};
      v[1] = '{OP_SUB, 8'd3,   8'd1,   8'd2,   1'b0, 1'b0, 1'b0};
      v[2] = '{OP_XOR, 8'hFF,  8'h0F,  8'hF0,  1'b0, 1'b0, 1'b0};
      v[3] = '{OP_SHL, 8'h40,  8'h00,  8'h80,  1'b0, 1'b0, 1'b0};
      v[4] = '{OP_EQ,  8'd5,   8'd5,   8'd1,   1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, v[i].op, v[i].a, v[i].b);
         n_assert++;
         if ({bus.out_valid, bus.result, bus.carry_flag, bus.zero_flag} !== {1'b1, v[i].r, v[i].c, v[i].z}) begin
            n_fail++;
            $display("FAIL b2b[%0d]: valid=%b result=%0d carry=%b zero=%b, required 1/%0d/%b/%b",
                     i, bus.out_valid, bus.result, bus.carry_flag, bus.zero_flag, v[i].r, v[i].c, v[i].z);
         end
      end
      drive(1'b0, OP_ADD, 8'd0, 8'd0);
      n_assert++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drop: valid=%b required 0", bus.out_valid);
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.op_code  = OP_ADD;
      bus.A        = '0;
      bus.B        = '0;
      test_reset();
      test_add();
      test_sub();
      test_logic_cmp();
      test_shl();
      test_hold();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_alu_core
